// File: rtl/pll_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_rst_pkg
// Brief   : Shared types and helpers for the PLL reset sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pll_rst_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    MEM_REL   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  // Wide enough for the largest of the four cycle parameters, plus one bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Brief   : Generic 1-bit two-flop synchronizer, asynchronous reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : Resets the PLL, waits for stable lock, then releases mem and core
//           resets in order. Status outputs need PLL_RESET_SEQUENCER_STATUS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MEM_TO_CORE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic               pll_rst,
  output logic               mem_rst,
  output logic               core_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  localparam int c_cnt_w = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                     LOCK_STABLE_CYCLES, MEM_TO_CORE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_pll_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s high is stable cycle one.
  localparam logic [c_cnt_w-1:0] c_stable_last  =
    c_cnt_w'((LOCK_STABLE_CYCLES > 1) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [c_cnt_w-1:0] c_mem_last     = c_cnt_w'(MEM_TO_CORE_CYCLES - 1);

  seq_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pll_rst;
  logic               r_mem_rst;
  logic               r_core_rst;
  logic               r_ready;

  logic w_lock_s;
  logic w_lock_loss;
  logic w_sw_abort;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_s)
  );

  assign w_lock_loss = ((r_state == MEM_REL) || (r_state == RUN)) && !w_lock_s;
  assign w_sw_abort  = sw_rst_req && (r_state != PLL_RST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PLL_RST;
      r_cnt      <= '0;
      r_pll_rst  <= 1'b1;
      r_mem_rst  <= 1'b1;
      r_core_rst <= 1'b1;
      r_ready    <= 1'b0;
    end else if (w_lock_loss || w_sw_abort) begin
      // Every reset reasserts on the same edge so core never leads mem.
      r_state    <= PLL_RST;
      r_cnt      <= '0;
      r_pll_rst  <= 1'b1;
      r_mem_rst  <= 1'b1;
      r_core_rst <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == c_pll_last) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_timeout_last) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_state   <= MEM_REL;
            r_cnt     <= '0;
            r_mem_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        MEM_REL: begin
          if (r_cnt == c_mem_last) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_core_rst <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        RUN: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_state    <= PLL_RST;
          r_cnt      <= '0;
          r_pll_rst  <= 1'b1;
          r_mem_rst  <= 1'b1;
          r_core_rst <= 1'b1;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst  = r_pll_rst;
  assign mem_rst  = r_mem_rst;
  assign core_rst = r_core_rst;
  assign ready    = r_ready;

`ifdef PLL_RESET_SEQUENCER_STATUS_EN
  logic [RETRY_W-1:0] r_retry_cnt;
  logic               r_lock_lost;
  logic               w_timeout;

  // A soft reset pre-empts the timeout, so it is not counted as a retry.
  assign w_timeout = (r_state == WAIT_LOCK) && !w_lock_s && !sw_rst_req &&
                     (r_cnt == c_timeout_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retry_cnt <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      if (w_lock_loss) begin
        r_lock_lost <= 1'b1;
      end
      if (w_timeout && (r_retry_cnt != '1)) begin
        r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
      end
    end
  end

  assign retry_cnt = r_retry_cnt;
  assign lock_lost = r_lock_lost;
`else
  assign retry_cnt = '0;
  assign lock_lost = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pll_reset_sequencer
// Brief   : Scoreboard bench for pll_reset_sequencer (small cycle parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int c_pll_cyc = 4;
  localparam int c_timeout = 20;
  localparam int c_stable  = 8;
  localparam int c_m2c     = 5;
`ifdef PLL_RESET_SEQUENCER_STATUS_EN
  localparam int c_status  = 1;
`else
  localparam int c_status  = 0;
`endif

  localparam int SIG_PLL  = 0;
  localparam int SIG_MEM  = 1;
  localparam int SIG_CORE = 2;
  localparam int SIG_RDY  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       mem_rst;
  logic       core_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (c_pll_cyc),
    .LOCK_TIMEOUT       (c_timeout),
    .LOCK_STABLE_CYCLES (c_stable),
    .MEM_TO_CORE_CYCLES (c_m2c)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .pll_rst    (pll_rst),
    .mem_rst    (mem_rst),
    .core_rst   (core_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    check_val("sb_nonempty", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic push_all(input string p, input int pr, input int mr, input int cr,
                          input int rd, input int rc, input int ll);
    sb_push({p, "_pll_rst"},   pr);
    sb_push({p, "_mem_rst"},   mr);
    sb_push({p, "_core_rst"},  cr);
    sb_push({p, "_ready"},     rd);
    sb_push({p, "_retry_cnt"}, rc);
    sb_push({p, "_lock_lost"}, ll);
  endtask

  task automatic snap();
    sb_pop(32'(pll_rst));
    sb_pop(32'(mem_rst));
    sb_pop(32'(core_rst));
    sb_pop(32'(ready));
    sb_pop(32'(retry_cnt));
    sb_pop(32'(lock_lost));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int s);
    case (s)
      SIG_PLL:  return pll_rst;
      SIG_MEM:  return mem_rst;
      SIG_CORE: return core_rst;
      default:  return ready;
    endcase
  endfunction

  // Edges until the selected output reaches v; stops at the budget.
  task automatic count_until(input int s, input logic v, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((sel(s) !== v) && (n < budget));
  endtask

  // core_rst released while mem_rst still asserted is never legal.
  always @(negedge clk) begin
    check_val("order_core_before_mem", 32'(!core_rst && mem_rst), 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) tick();
    push_all("reset", 1, 1, 1, 0, 0, 0);
    snap();

    // Normal bring-up.
    rst = 1'b0;
    sb_push("bringup_pll_rst_cycles", c_pll_cyc);
    count_until(SIG_PLL, 1'b0, 50, n);
    sb_pop(n);
    repeat (3) tick();
    pll_locked = 1'b1;
    sb_push("lock_to_mem_rel", 2 + c_stable);
    count_until(SIG_MEM, 1'b0, 100, n);
    sb_pop(n);
    sb_push("mem_to_core_rel", c_m2c);
    count_until(SIG_CORE, 1'b0, 100, n);
    sb_pop(n);
    push_all("run", 0, 0, 0, 1, 0, 0);
    snap();

    // Soft reset from RUN, then again in MEM_REL.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    push_all("sw_in_run", 1, 1, 1, 0, 0, 0);
    snap();
    sb_push("sw_relock_to_mem_rel", c_pll_cyc + 1 + (c_stable - 1));
    count_until(SIG_MEM, 1'b0, 100, n);
    sb_pop(n);
    repeat (2) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    push_all("sw_in_memrel", 1, 1, 1, 0, 0, 0);
    snap();

    // Lock glitch while STABLE count is 5.
    sb_push("glitch_pll_rst_cycles", c_pll_cyc);
    count_until(SIG_PLL, 1'b0, 50, n);
    sb_pop(n);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    sb_push("glitch_restore_to_mem_rel", 2 + c_stable);
    count_until(SIG_MEM, 1'b0, 100, n);
    sb_pop(n);
    sb_push("glitch_mem_to_core", c_m2c);
    count_until(SIG_CORE, 1'b0, 100, n);
    sb_pop(n);

    // Lock loss in RUN: two synchronizer edges, then the FSM edge.
    pll_locked = 1'b0;
    sb_push("loss_latency", 3);
    count_until(SIG_MEM, 1'b1, 20, n);
    sb_pop(n);
    push_all("loss", 1, 1, 1, 0, 0, c_status);
    snap();
    pll_locked = 1'b1;
    sb_push("relock_to_ready", c_pll_cyc + 1 + (c_stable - 1) + c_m2c);
    count_until(SIG_RDY, 1'b1, 200, n);
    sb_pop(n);
    push_all("relock", 0, 0, 0, 1, 0, c_status);
    snap();

    // Timeout retries with lock held low.
    pll_locked = 1'b0;
    sb_push("loss2_latency", 3);
    count_until(SIG_PLL, 1'b1, 20, n);
    sb_pop(n);
    sb_push("loss2_pll_rst_cycles", c_pll_cyc);
    count_until(SIG_PLL, 1'b0, 50, n);
    sb_pop(n);
    for (int i = 1; i <= 17; i++) begin
      sb_push("timeout_window", c_timeout);
      count_until(SIG_PLL, 1'b1, 100, n);
      sb_pop(n);
      sb_push("timeout_retry_cnt", (c_status != 0) ? ((i > 15) ? 15 : i) : 0);
      sb_pop(32'(retry_cnt));
      sb_push("timeout_pll_rst_cycles", c_pll_cyc);
      count_until(SIG_PLL, 1'b0, 50, n);
      sb_pop(n);
    end

    // Asynchronous reset between edges while in RUN.
    pll_locked = 1'b1;
    sb_push("final_lock_to_ready", 2 + c_stable + c_m2c);
    count_until(SIG_RDY, 1'b1, 200, n);
    sb_pop(n);
    #3;
    rst = 1'b1;
    #1;
    push_all("async_rst", 1, 1, 1, 0, 0, 0);
    snap();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check_val("sb_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
